// File: rtl/usr_deserializer.sv
// usr_deserializer: receive side of the universal-shift-register serial link.
// Collects bits MSB-first or LSB-first (direction latched with the first bit of
// each word), rebuilds WIDTH-bit words, and presents them through a one-entry
// valid/ready holding register. A completed word that finds the holder full is
// dropped and the sticky overrun flag is raised; flush discards a partial word
// and clears overrun.
// Optional feature macro: USR_DESER_PARITY_EN (adds one trailing even-parity bit
// per word and drives parity_err; when undefined parity_err is tied low).
//
// state | meaning
// ------+-------------------------------------------
// IDLE  | no partial word; next ser_valid bit starts one
// RECV  | partial word in progress (busy)
module usr_deserializer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             ser_in,
    input  logic             ser_valid,
    input  logic             dir,
    input  logic             flush,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             parity_err,
    output logic             busy
);

`ifdef USR_DESER_PARITY_EN
    localparam int LAST_IDX = WIDTH;
`else
    localparam int LAST_IDX = WIDTH - 1;
`endif
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LAST_IDX);

    typedef enum logic {IDLE, RECV} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               overrun_q, overrun_d;

    logic               dir_eff;
    logic [WIDTH-1:0]   sh_shift;
    logic [WIDTH-1:0]   word_nxt;
    logic               is_data_bit;
    logic               complete;

`ifdef USR_DESER_PARITY_EN
    logic               par_q, par_d;
    logic               parity_err_q, parity_err_d;

    // The parity bit is the last one of the word and is never shifted in.
    assign is_data_bit = (cnt_q != LAST);
    assign word_nxt    = sh_q;
    assign parity_err  = parity_err_q;
`else
    assign is_data_bit = 1'b1;
    assign word_nxt    = sh_shift;
    assign parity_err  = 1'b0;
`endif

    // A new word takes its direction from the live dir input on its first bit.
    assign dir_eff  = (state_q == IDLE) ? dir : dir_q;
    assign sh_shift = dir_eff ? {sh_q[WIDTH-2:0], ser_in} : {ser_in, sh_q[WIDTH-1:1]};

    // Next-state: bit collection, FSM, holder load/accept and overrun.
    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        complete    = 1'b0;
`ifdef USR_DESER_PARITY_EN
        par_d        = par_q;
        parity_err_d = parity_err_q;
`endif

        if (flush) begin
            state_d   = IDLE;
            sh_d      = '0;
            cnt_d     = '0;
            overrun_d = 1'b0;
`ifdef USR_DESER_PARITY_EN
            par_d     = 1'b0;
`endif
        end else if (ser_valid) begin
            dir_d = dir_eff;
            if (is_data_bit) begin
                sh_d = sh_shift;
            end
`ifdef USR_DESER_PARITY_EN
            par_d = par_q ^ ser_in;
`endif
            if (cnt_q == LAST) begin
                complete = 1'b1;
                state_d  = IDLE;
                cnt_d    = '0;
                sh_d     = '0;
`ifdef USR_DESER_PARITY_EN
                par_d    = 1'b0;
`endif
            end else begin
                state_d = RECV;
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end

        if (complete) begin
            if (!out_valid_q || out_ready) begin
                out_data_d  = word_nxt;
                out_valid_d = 1'b1;
`ifdef USR_DESER_PARITY_EN
                parity_err_d = par_q ^ ser_in;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef USR_DESER_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
`ifdef USR_DESER_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q == RECV);

endmodule

// File: tb/tb_usr_deserializer.sv
// Self-checking bench for usr_deserializer: a word-level reference model runs
// alongside the DUT and is compared every cycle, plus literal checks that pin
// the expected words of the directed scenarios.
module tb_usr_deserializer;

    localparam int WIDTH = 4;
`ifdef USR_DESER_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             clear = 1'b0;
    logic             ser_in = 1'b0;
    logic             ser_valid = 1'b0;
    logic             dir = 1'b1;
    logic             flush = 1'b0;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             overrun;
    logic             parity_err;
    logic             busy;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    usr_deserializer #(.WIDTH(WIDTH), .CNT_W(3)) dut (
        .clk        (clk),
        .clear      (clear),
        .ser_in     (ser_in),
        .ser_valid  (ser_valid),
        .dir        (dir),
        .flush      (flush),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overrun    (overrun),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference model: words are assembled from a bit list with plain arithmetic.
    bit         m_bits[$];
    bit         m_dir;
    logic [WIDTH-1:0] m_data;
    logic       m_valid, m_ovr, m_perr;

    always @(posedge clk or negedge clear) begin
        bit done;
        int w;
        bit p;
        if (!clear) begin
            m_bits.delete();
            m_dir = 1'b0;
            m_data = '0; m_valid = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
        end else begin
            done = 1'b0; w = 0; p = 1'b0;
            if (flush) begin
                m_bits.delete();
                m_ovr = 1'b0;
            end else if (ser_valid) begin
                if (m_bits.size() == 0) m_dir = dir;
                m_bits.push_back(ser_in);
                if (m_bits.size() == NBITS) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (m_dir) w += int'(m_bits[i]) * (2 ** (WIDTH - 1 - i));
                        else       w += int'(m_bits[i]) * (2 ** i);
                    end
                    for (int i = 0; i < NBITS; i++) p ^= m_bits[i];
                    done = 1'b1;
                    m_bits.delete();
                end
            end
            if (done) begin
                if (!m_valid || out_ready) begin
                    m_data = w[WIDTH-1:0];
                    m_valid = 1'b1;
`ifdef USR_DESER_PARITY_EN
                    m_perr = p;
`else
                    m_perr = 1'b0;
`endif
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model.out_valid", int'(out_valid), int'(m_valid));
            if (m_valid) chk("model.out_data", int'(out_data), int'(m_data));
            chk("model.overrun", int'(overrun), int'(m_ovr));
            chk("model.parity_err", int'(parity_err), int'(m_perr));
            chk("model.busy", int'(busy), int'(m_bits.size() != 0));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input bit b);
        ser_valid = 1'b1;
        ser_in = b;
        tick();
        ser_valid = 1'b0;
    endtask

    task automatic send_word(input logic [3:0] bits_msb_order);
        logic [3:0] v;
        v = bits_msb_order;
        for (int i = 3; i >= 0; i--) send(v[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // Reset state
        #1;
        chk("reset.out_data", int'(out_data), 0);
        chk("reset.out_valid", int'(out_valid), 0);
        chk("reset.overrun", int'(overrun), 0);
        chk("reset.busy", int'(busy), 0);
        @(negedge clk);
        clear = 1'b1;
        chk_en = 1'b1;
        idle(2);

`ifndef USR_DESER_PARITY_EN
        // 1: MSB-first, consecutive bits
        dir = 1'b1;
        send_word(4'b1011);
        chk("t1.data", int'(out_data), 4'b1011);
        chk("t1.valid", int'(out_valid), 1);
        tick();
        chk("t1.valid_drop", int'(out_valid), 0);

        // 2: LSB-first with one idle gap after bit 2
        dir = 1'b0;
        send(1); send(0); idle(1); send(1); send(1);
        chk("t2.data", int'(out_data), 4'b1101);
        chk("t2.valid", int'(out_valid), 1);
        idle(2);

        // 3: stalled consumer, overrun, drain, flush
        dir = 1'b1;
        out_ready = 1'b0;
        send_word(4'hA);
        chk("t3.first", int'(out_data), 4'hA);
        send_word(4'h5);
        chk("t3.held", int'(out_data), 4'hA);
        chk("t3.overrun", int'(overrun), 1);
        chk("t3.still_valid", int'(out_valid), 1);
        out_ready = 1'b1;
        tick();
        chk("t3.drained", int'(out_valid), 0);
        chk("t3.ovr_sticky", int'(overrun), 1);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("t3.ovr_clr", int'(overrun), 0);

        // 4: flush mid-word, then dir toggled mid-word is ignored
        dir = 1'b1;
        send(1); send(1);
        chk("t4.busy", int'(busy), 1);
        flush = 1'b1; ser_valid = 1'b1; ser_in = 1'b1; tick();
        flush = 1'b0; ser_valid = 1'b0;
        chk("t4.flushed", int'(busy), 0);
        send(0); dir = 1'b0; send(1); dir = 1'b1; send(1); dir = 1'b0; send(0);
        chk("t4.data", int'(out_data), 4'b0110);
        dir = 1'b1;
        idle(2);

        // 5: async clear mid-word
        send(1); send(0); send(1);
        #2 clear = 1'b0;
        #1;
        chk("t5.data0", int'(out_data), 0);
        chk("t5.valid0", int'(out_valid), 0);
        chk("t5.busy0", int'(busy), 0);
        @(negedge clk);
        clear = 1'b1;
        send_word(4'b1110);
        chk("t5.data", int'(out_data), 4'b1110);
        idle(1);

        // Accept and completion on the same edge: no bubble
        out_ready = 1'b0;
        send_word(4'hC);
        send(0); send(0); send(1);
        out_ready = 1'b1;
        send(1);
        chk("nb.data", int'(out_data), 4'h3);
        chk("nb.valid", int'(out_valid), 1);
        chk("nb.no_ovr", int'(overrun), 0);
        tick();
        chk("nb.drop", int'(out_valid), 0);

        // Back-to-back words with no gap
        send_word(4'h9); 
        chk("b2b.first", int'(out_data), 4'h9);
        send_word(4'h6);
        chk("b2b.second", int'(out_data), 4'h6);
        idle(2);
`else
        // 6: parity variants
        dir = 1'b1;
        send_word(4'b1011); send(1);
        chk("t6.data", int'(out_data), 4'b1011);
        chk("t6.perr0", int'(parity_err), 0);
        send_word(4'b1011); send(0);
        chk("t6.perr1", int'(parity_err), 1);
        out_ready = 1'b0;
        send_word(4'b0011); send(0);
        send_word(4'b0111); out_ready = 1'b1; send(1);
        chk("t6.b2b_valid", int'(out_valid), 1);
        chk("t6.b2b_data", int'(out_data), 4'b0111);
        chk("t6.b2b_perr", int'(parity_err), 0);
        idle(2);
`endif
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
